ln_stage1_stat_accum: RTL and testbench

LN_STAGE1_STAT_ACCUM -- requirements
Module: ln_stage1_stat_accum

---
 rtl/ln_pkg.sv | 25 ++
 rtl/ln_lane_sq_reduce.sv | 90 +++++++++
 rtl/ln_stage1_stat_accum.sv | 126 ++++++++++++
 tb/tb_ln_stage1_stat_accum.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ln_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ln_pkg
// Description : Shared widths and types for the LayerNorm statistics path.
//               The stat-calc stage imports the same constants so the sum and
//               square-sum buses agree end to end.
// Revision    : 1.0 - initial release
// ============================================================================
package ln_pkg;

   localparam int LN_N_ELEM = 768;  // elements per LayerNorm vector
   localparam int LN_LANES  = 4;    // samples per beat
   localparam int LN_DATA_W = 20;   // signed sample width
   localparam int LN_SUM_W  = 31;   // signed running-sum width
   localparam int LN_SQ_W   = 51;   // square-sum width

   // Qualifier bits that travel alongside each beat down the pipeline.
   typedef struct packed {
      logic valid;
      logic first;
      logic last;
   } ln_tag_t;

endpackage : ln_pkg
`default_nettype wire

// File: rtl/ln_lane_sq_reduce.sv
`default_nettype none
// ============================================================================
// Module      : ln_lane_sq_reduce
// Description : Two-stage per-beat front end. P1 registers the raw lane
//               samples and their exact squares; P2 registers the lane sum
//               (sign-extended) and the lane square sum with the beat tags.
// Revision    : 1.0 - initial release
// ============================================================================
module ln_lane_sq_reduce
   import ln_pkg::*;
#(
   parameter int LANES  = LN_LANES,
   parameter int DATA_W = LN_DATA_W,
   parameter int LSUM_W = LN_DATA_W + $clog2(LN_LANES),
   parameter int LSQ_W  = 2*LN_DATA_W + $clog2(LN_LANES)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     en_i,
   input  logic                     valid_i,
   input  logic                     first_i,
   input  logic                     last_i,
   input  logic [LANES*DATA_W-1:0]  data_i,
   output logic                     valid_o,
   output logic                     first_o,
   output logic                     last_o,
   output logic signed [LSUM_W-1:0] sum_o,
   output logic [LSQ_W-1:0]         sq_o
);

   localparam int SQ_W = 2*DATA_W;

   logic [LANES*DATA_W-1:0] p1_smp_q;
   logic [LANES*SQ_W-1:0]   p1_sq_d;
   logic [LANES*SQ_W-1:0]   p1_sq_q;
   ln_tag_t                 p1_tag_d;
   ln_tag_t                 p1_tag_q;
   ln_tag_t                 p2_tag_q;
   logic signed [LSUM_W-1:0] p2_sum_d;
   logic signed [LSUM_W-1:0] p2_sum_q;
   logic [LSQ_W-1:0]        p2_sq_d;
   logic [LSQ_W-1:0]        p2_sq_q;

   // Exact squares: sign-extend to the full product width so the low
   // 2*DATA_W bits of the product are the true (non-negative) square.
   for (genvar l = 0; l < LANES; l++) begin : g_sq
      logic signed [SQ_W-1:0] w_ext;
      assign w_ext = SQ_W'($signed(data_i[l*DATA_W +: DATA_W]));
      assign p1_sq_d[l*SQ_W +: SQ_W] = w_ext * w_ext;
   end

   assign p1_tag_d = '{valid: valid_i, first: first_i & valid_i, last: last_i & valid_i};

   // Lane reduction of the P1 contents.
   always_comb begin
      p2_sum_d = '0;
      p2_sq_d  = '0;
      for (int l = 0; l < LANES; l++) begin
         p2_sum_d = p2_sum_d + LSUM_W'($signed(p1_smp_q[l*DATA_W +: DATA_W]));
         p2_sq_d  = p2_sq_d  + LSQ_W'(p1_sq_q[l*SQ_W +: SQ_W]);
      end
   end

   // P1/P2 pipeline registers; the enable freezes everything.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         p1_smp_q <= '0;
         p1_sq_q  <= '0;
         p1_tag_q <= '0;
         p2_tag_q <= '0;
         p2_sum_q <= '0;
         p2_sq_q  <= '0;
      end else if (en_i) begin
         p1_smp_q <= data_i;
         p1_sq_q  <= p1_sq_d;
         p1_tag_q <= p1_tag_d;
         p2_tag_q <= p1_tag_q;
         p2_sum_q <= p2_sum_d;
         p2_sq_q  <= p2_sq_d;
      end
   end

   assign valid_o = p2_tag_q.valid;
   assign first_o = p2_tag_q.first;
   assign last_o  = p2_tag_q.last;
   assign sum_o   = p2_sum_q;
   assign sq_o    = p2_sq_q;

endmodule : ln_lane_sq_reduce
`default_nettype wire

// File: rtl/ln_stage1_stat_accum.sv
`default_nettype none
// ============================================================================
// Module      : ln_stage1_stat_accum
// Description : LayerNorm stage 1. Accumulates sum and sum of squares over
//               N_ELEM samples (LANES per beat) and hands the totals to the
//               stat-calc stage with a one-cycle o_start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module ln_stage1_stat_accum
   import ln_pkg::*;
#(
   parameter int N_ELEM = LN_N_ELEM,
   parameter int LANES  = LN_LANES,
   parameter int DATA_W = LN_DATA_W
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_en,
   input  logic                       i_valid,
   input  logic [LANES*DATA_W-1:0]    i_data,
   output logic signed [LN_SUM_W-1:0] o_sum,
   output logic [LN_SQ_W-1:0]         o_sq_sum,
   output logic                       o_start,
   output logic                       o_busy
);

   localparam int BEATS  = N_ELEM / LANES;
   localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LSUM_W = DATA_W + $clog2(LANES);
   localparam int LSQ_W  = 2*DATA_W + $clog2(LANES);

   logic [CNT_W-1:0]          cnt_d, cnt_q;
   logic                      w_accept, w_first, w_last;
   logic                      w_p2_valid, w_p2_first, w_p2_last;
   logic signed [LSUM_W-1:0]  w_p2_sum;
   logic [LSQ_W-1:0]          w_p2_sq;
   logic signed [LN_SUM_W-1:0] acc_sum_d, acc_sum_q;
   logic [LN_SQ_W-1:0]        acc_sq_d, acc_sq_q;
   logic signed [LN_SUM_W-1:0] out_sum_d, out_sum_q;
   logic [LN_SQ_W-1:0]        out_sq_d, out_sq_q;
   logic                      start_d, start_q;

   assign w_accept = i_en & i_valid;
   assign w_first  = (cnt_q == '0);
   assign w_last   = (cnt_q == CNT_W'(BEATS - 1));

   // Beat counter: advances per accepted beat and wraps on the closing beat.
   always_comb begin
      cnt_d = cnt_q;
      if (w_accept) begin
         cnt_d = w_last ? '0 : cnt_q + CNT_W'(1);
      end
   end

   ln_lane_sq_reduce #(
      .LANES  (LANES),
      .DATA_W (DATA_W),
      .LSUM_W (LSUM_W),
      .LSQ_W  (LSQ_W)
   ) u_reduce (
      .clk_i   (i_clk),
      .rst_ni  (i_rst_n),
      .en_i    (i_en),
      .valid_i (i_valid),
      .first_i (w_first),
      .last_i  (w_last),
      .data_i  (i_data),
      .valid_o (w_p2_valid),
      .first_o (w_p2_first),
      .last_o  (w_p2_last),
      .sum_o   (w_p2_sum),
      .sq_o    (w_p2_sq)
   );

   // P3: a first-flag beat restarts the totals so vector k never leaks into
   // k+1; a last-flag beat publishes the completed totals.
   always_comb begin
      acc_sum_d = acc_sum_q;
      acc_sq_d  = acc_sq_q;
      out_sum_d = out_sum_q;
      out_sq_d  = out_sq_q;
      start_d   = 1'b0;
      if (w_p2_valid) begin
         if (w_p2_first) begin
            acc_sum_d = LN_SUM_W'(w_p2_sum);
            acc_sq_d  = LN_SQ_W'(w_p2_sq);
         end else begin
            acc_sum_d = acc_sum_q + LN_SUM_W'(w_p2_sum);
            acc_sq_d  = acc_sq_q  + LN_SQ_W'(w_p2_sq);
         end
         if (w_p2_last) begin
            out_sum_d = acc_sum_d;
            out_sq_d  = acc_sq_d;
            start_d   = 1'b1;
         end
      end
   end

   // Counter, accumulator and output registers; frozen while i_en is low.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q     <= '0;
         acc_sum_q <= '0;
         acc_sq_q  <= '0;
         out_sum_q <= '0;
         out_sq_q  <= '0;
         start_q   <= 1'b0;
      end else if (i_en) begin
         cnt_q     <= cnt_d;
         acc_sum_q <= acc_sum_d;
         acc_sq_q  <= acc_sq_d;
         out_sum_q <= out_sum_d;
         out_sq_q  <= out_sq_d;
         start_q   <= start_d;
      end
   end

   // A pulse held through an i_en-low window stays pending in start_q and
   // appears on the first enabled cycle, then clears on that cycle's edge.
   assign o_start  = start_q & i_en;
   assign o_sum    = out_sum_q;
   assign o_sq_sum = out_sq_q;
   assign o_busy   = (cnt_q != '0);

endmodule : ln_stage1_stat_accum
`default_nettype wire

// File: tb/tb_ln_stage1_stat_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_ln_stage1_stat_accum
// Description : Directed self-checking bench for ln_stage1_stat_accum.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ln_stage1_stat_accum;

   localparam int LANES = 4;
   localparam int DW    = 20;
   localparam int BEATS = 192;

   logic                 i_clk = 1'b0;
   logic                 i_rst_n;
   logic                 i_en;
   logic                 i_valid;
   logic [LANES*DW-1:0]  i_data;
   logic signed [30:0]   o_sum;
   logic [50:0]          o_sq_sum;
   logic                 o_start;
   logic                 o_busy;

   int     n_assert = 0;
   int     n_fail   = 0;
   longint act_cnt  = 0;
   longint last_stamp;
   longint exp_sum, exp_sq;
   longint first_stamp;
   longint st_stamp[$];
   longint st_sum[$];
   longint st_sq[$];

   ln_stage1_stat_accum dut (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_en     (i_en),
      .i_valid  (i_valid),
      .i_data   (i_data),
      .o_sum    (o_sum),
      .o_sq_sum (o_sq_sum),
      .o_start  (o_start),
      .o_busy   (o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: drive at the falling edge, observe 1 ns later.
   task automatic step(input logic en, input logic vld, input logic [LANES*DW-1:0] d);
      longint cur;
      @(negedge i_clk);
      i_en = en; i_valid = vld; i_data = d;
      #1;
      cur = act_cnt;
      if (en) act_cnt++;
      if (!en) chk("start_while_en_low", longint'(o_start), 0);
      if (o_start === 1'b1) begin
         st_stamp.push_back(cur);
         st_sum.push_back(longint'(o_sum));
         st_sq.push_back(longint'(o_sq_sum));
      end
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0);
   endtask

   task automatic clear_q();
      st_stamp.delete(); st_sum.delete(); st_sq.delete();
   endtask

   // kind 0: constant param, 1: ramp 0..767, 2: pseudo-random pattern.
   // gaps: insert i_valid-low cycles and i_en-low windows (valid held high).
   task automatic send_vec(input int kind, input longint param, input bit gaps);
      logic [LANES*DW-1:0] d;
      longint v;
      exp_sum = 0; exp_sq = 0;
      for (int b = 0; b < BEATS; b++) begin
         for (int l = 0; l < LANES; l++) begin
            case (kind)
               0:       v = param;
               1:       v = 4*b + l;
               default: v = ((4*b + l) * 37) % 201 - 100;
            endcase
            d[l*DW +: DW] = v[DW-1:0];
            exp_sum += v;
            exp_sq  += v*v;
         end
         if (gaps && (b % 7 == 3)) step(1'b1, 1'b0, ~d);
         if (gaps && (b % 23 == 5)) begin
            step(1'b0, 1'b1, ~d);
            step(1'b0, 1'b1, ~d);
         end
         last_stamp = act_cnt;
         step(1'b1, 1'b1, d);
      end
   endtask

   task automatic check_one(input string tag, input longint esum, input longint esq);
      chk({tag, "_starts"}, st_stamp.size(), 1);
      if (st_stamp.size() > 0) begin
         chk({tag, "_latency"}, st_stamp[0] - last_stamp, 3);
         chk({tag, "_sum"}, st_sum[0], esum);
         chk({tag, "_sq"}, st_sq[0], esq);
      end
      clear_q();
   endtask

   initial begin
      i_rst_n = 1'b0; i_en = 1'b0; i_valid = 1'b0; i_data = '0;
      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_sum", longint'(o_sum), 0);
      chk("rst_sq", longint'(o_sq_sum), 0);
      chk("rst_start", longint'(o_start), 0);
      chk("rst_busy", longint'(o_busy), 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // All +1, continuous.
      send_vec(0, 1, 1'b0);
      chk("busy_mid", longint'(o_busy), 1);
      drain(6);
      chk("busy_end", longint'(o_busy), 0);
      check_one("ones", 768, 768);

      // Negative full scale: 768 * -2^19 and 768 * 2^38.
      send_vec(0, -524288, 1'b0);
      drain(6);
      check_one("negfs", -402653184, 64'd211106232532992);

      // Positive full scale: 768*524287 and 768*(2^38 - 2^20 + 1).
      send_vec(0, 524287, 1'b0);
      drain(6);
      check_one("posfs", 402652416, 64'd211105427227392);

      // Back-to-back: ramp 0..767 (sum n(n-1)/2, squares 767*768*1535/6),
      // then all 2, no idle beat between.
      send_vec(1, 0, 1'b0);
      first_stamp = last_stamp;
      send_vec(0, 2, 1'b0);
      chk("b2b_hold", longint'(o_sum), 294528);
      drain(6);
      chk("b2b_starts", st_stamp.size(), 2);
      if (st_stamp.size() == 2) begin
         chk("b2b_lat0", st_stamp[0] - first_stamp, 3);
         chk("b2b_sum0", st_sum[0], 294528);
         chk("b2b_sq0", st_sq[0], 150700160);
         chk("b2b_sum1", st_sum[1], 1536);
         chk("b2b_sq1", st_sq[1], 3072);
         chk("b2b_spacing", st_stamp[1] - st_stamp[0], 192);
      end
      clear_q();

      // Gaps in i_valid and i_en, plus an i_en-low window over the pending
      // o_start: the pulse must wait for i_en and still be one cycle wide.
      send_vec(2, 0, 1'b1);
      step(1'b1, 1'b0, '0);
      step(1'b1, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      drain(6);
      check_one("gaps", exp_sum, exp_sq);

      // Reset after beat 100 of a vector.
      for (int b = 0; b < 101; b++) step(1'b1, 1'b1, {LANES{20'd5}});
      @(negedge i_clk);
      #2 i_rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", longint'(o_busy), 0);
      chk("mid_rst_sum", longint'(o_sum), 0);
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // Reset with the closing beat still in the pipeline.
      send_vec(0, 7, 1'b0);
      step(1'b1, 1'b0, '0);
      @(negedge i_clk);
      #2 i_rst_n = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b1;

      send_vec(0, 3, 1'b0);
      drain(6);
      check_one("after_rst", 2304, 6912);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_ln_stage1_stat_accum
`default_nettype wire
